// File: rtl/pin_entry_controller.sv
// pin_entry_controller: keypad sequencer in front of the combination-lock FSM.
// Collects four hex digits into a PIN, pulses trig, samples lock_state after a
// response delay, and manages failed-attempt lockout and auto-relock.
// Optional build macro: PIN_ENTRY_TIMEOUT_EN (discard idle partial entries).
module pin_entry_controller #(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned RESP_CYCLES    = 4,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned RELOCK_CYCLES  = 5000,
  parameter int unsigned ENTRY_TIMEOUT  = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic [1:0]  lock_state,
  output logic [15:0] pin_code,
  output logic        trig,
  output logic        lock,
  output logic [2:0]  digit_cnt,
  output logic [3:0]  fail_cnt,
  output logic        busy,
  output logic        lockout
);

  // One shared timer serves every timed state, so size it for the longest interval.
  localparam int unsigned T_A  = (RESP_CYCLES > LOCKOUT_CYCLES) ? RESP_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned T_B  = (RELOCK_CYCLES > ENTRY_TIMEOUT) ? RELOCK_CYCLES : ENTRY_TIMEOUT;
  localparam int unsigned TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RESP_LAST    = TW'(RESP_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] RELOCK_LAST  = TW'(RELOCK_CYCLES - 1);
`ifdef PIN_ENTRY_TIMEOUT_EN
  localparam logic [TW-1:0] ENTRY_LAST   = TW'(ENTRY_TIMEOUT - 1);
`endif
  localparam logic [3:0]    MAX_FAIL_L   = 4'(MAX_FAIL);
  localparam logic [1:0]    UNLOCKED     = 2'b01;

  typedef enum logic [2:0] {
    IDLE, ENTRY, SUBMIT, WAIT, OPEN, LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   pin_n;
  logic [2:0]    digit_n;
  logic [3:0]    fail_n, fail_inc;
  logic          trig_n, lock_n;

  assign fail_inc = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

  // State, timer and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pin_code  <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      trig      <= 1'b0;
      lock      <= 1'b0;
      busy      <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      pin_code  <= pin_n;
      digit_cnt <= digit_n;
      fail_cnt  <= fail_n;
      trig      <= trig_n;
      lock      <= lock_n;
      busy      <= (state_n == SUBMIT) || (state_n == WAIT);
      lockout   <= (state_n == LOCKOUT);
    end
  end

  // Next-state and next-output decode; key priority is clear > enter > digit.
  always_comb begin
    state_n = state;
    timer_n = timer;
    pin_n   = pin_code;
    digit_n = digit_cnt;
    fail_n  = fail_cnt;
    trig_n  = 1'b0;
    lock_n  = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (key_clear) begin
          pin_n   = '0;
          digit_n = '0;
          state_n = IDLE;
        end else if (key_enter && digit_cnt == 3'd4) begin
          trig_n  = 1'b1;
          state_n = SUBMIT;
        end else if (key_enter && digit_cnt != 3'd0) begin
          // Short entry is treated exactly like a rejected PIN.
          pin_n   = '0;
          digit_n = '0;
          fail_n  = fail_inc;
          timer_n = '0;
          state_n = (fail_inc >= MAX_FAIL_L) ? LOCKOUT : IDLE;
        end else if (key_valid) begin
          if (digit_cnt != 3'd4) begin
            pin_n   = {pin_code[11:0], key_code};
            digit_n = digit_cnt + 3'd1;
          end
          timer_n = '0;
          state_n = ENTRY;
        end
`ifdef PIN_ENTRY_TIMEOUT_EN
        else if (state == ENTRY) begin
          if (timer == ENTRY_LAST) begin
            pin_n   = '0;
            digit_n = '0;
            timer_n = '0;
            state_n = IDLE;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
`endif
      end
      SUBMIT: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (timer == RESP_LAST) begin
          pin_n   = '0;
          digit_n = '0;
          timer_n = '0;
          if (lock_state == UNLOCKED) begin
            fail_n  = '0;
            state_n = OPEN;
          end else begin
            fail_n  = fail_inc;
            state_n = (fail_inc >= MAX_FAIL_L) ? LOCKOUT : IDLE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      OPEN: begin
        if (key_clear || timer == RELOCK_LAST) begin
          lock_n  = 1'b1;
          timer_n = '0;
          state_n = IDLE;
        end else if (lock_state != UNLOCKED) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          fail_n  = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Scoreboard bench for pin_entry_controller: stimulus queues expected trig/lock
// pulses, a negedge monitor pops and compares them; status outputs are checked
// directly with hand-computed values.
module tb_pin_entry_controller;

  localparam int unsigned P_MAX_FAIL = 3;
  localparam int unsigned P_RESP     = 4;
  localparam int unsigned P_LOCKOUT  = 20;
  localparam int unsigned P_RELOCK   = 30;
  localparam int unsigned P_ENTRY_TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic [1:0]  lock_state = 2'b00;
  logic [15:0] pin_code;
  logic        trig;
  logic        lock;
  logic [2:0]  digit_cnt;
  logic [3:0]  fail_cnt;
  logic        busy;
  logic        lockout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int kt;

  typedef struct {
    bit          is_lock;
    logic [15:0] pin;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  pin_entry_controller #(
    .MAX_FAIL      (P_MAX_FAIL),
    .RESP_CYCLES   (P_RESP),
    .LOCKOUT_CYCLES(P_LOCKOUT),
    .RELOCK_CYCLES (P_RELOCK),
    .ENTRY_TIMEOUT (P_ENTRY_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .lock_state(lock_state),
    .pin_code  (pin_code),
    .trig      (trig),
    .lock      (lock),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt),
    .busy      (busy),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every trig/lock pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (trig || lock)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got trig=%0b lock=%0b at cyc=%0d, want no pulse", trig, lock, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_lock != lock || mon_e.is_lock == trig || mon_e.cyc != cyc ||
            (!mon_e.is_lock && pin_code != mon_e.pin)) begin
          bad++;
          $display("FAIL pulse_event: got trig=%0b lock=%0b pin=%04h cyc=%0d, want %s pin=%04h cyc=%0d",
                   trig, lock, pin_code, cyc, mon_e.is_lock ? "lock" : "trig", mon_e.pin, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic v, input logic [3:0] c, input logic e, input logic cl);
    @(negedge clk);
    key_valid = v;
    key_code  = c;
    key_enter = e;
    key_clear = cl;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic digit(input logic [3:0] c);
    press(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_trig(input logic [15:0] p);
    ev_t e;
    e.is_lock = 1'b0;
    e.pin     = p;
    e.cyc     = cyc;
    exp_q.push_back(e);
  endtask

  task automatic expect_lock(input int at);
    ev_t e;
    e.is_lock = 1'b1;
    e.pin     = '0;
    e.cyc     = at;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with a digit strobe held during reset.
    #3 rst = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    idle(1);
    check("rst_pin", 32'(pin_code), 0);
    check("rst_digit", 32'(digit_cnt), 0);
    check("rst_fail", 32'(fail_cnt), 0);
    check("rst_trig", 32'(trig), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lockout", 32'(lockout), 0);

    // Successful entry of ABCD.
    digit(4'hA);
    check("digit_a", 32'(digit_cnt), 1);
    digit(4'hB);
    digit(4'hC);
    digit(4'hD);
    check("pin_abcd", 32'(pin_code), 32'hABCD);
    check("digit_4", 32'(digit_cnt), 4);
    lock_state = 2'b01;
    press(1'b0, 4'h0, 1'b1, 1'b0);
    expect_trig(16'hABCD);
    check("busy_submit", 32'(busy), 1);
    idle(P_RESP + 1);
    check("open_fail", 32'(fail_cnt), 0);
    check("open_busy", 32'(busy), 0);
    check("open_digit", 32'(digit_cnt), 0);
    press(1'b0, 4'h0, 1'b0, 1'b1);
    expect_lock(cyc);
    idle(2);

    // Three wrong submissions lead to lockout.
    lock_state = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      digit(4'hD);
      digit(4'hA);
      digit(4'hD);
      digit(4'hA);
      press(1'b0, 4'h0, 1'b1, 1'b0);
      expect_trig(16'hDADA);
      idle(P_RESP + 1);
      check("fail_step", 32'(fail_cnt), 32'(i));
      check("lockout_step", 32'(lockout), (i == 3) ? 1 : 0);
    end
    digit(4'h7);
    check("lockout_key_ignored", 32'(digit_cnt), 0);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    idle(P_LOCKOUT - 3);
    check("lockout_still", 32'(lockout), 1);
    check("lockout_fail_held", 32'(fail_cnt), 3);
    idle(1);
    check("lockout_done", 32'(lockout), 0);
    check("lockout_fail_clr", 32'(fail_cnt), 0);

    // Short entry counts as a failure; fifth digit is ignored.
    digit(4'hB);
    digit(4'hA);
    check("short_digit", 32'(digit_cnt), 2);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    check("short_fail", 32'(fail_cnt), 1);
    check("short_digit_clr", 32'(digit_cnt), 0);
    check("short_pin_clr", 32'(pin_code), 0);
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    digit(4'h4);
    digit(4'h5);
    check("fifth_pin", 32'(pin_code), 32'h1234);
    check("fifth_digit", 32'(digit_cnt), 4);

    // Open, then auto-relock with no key.
    lock_state = 2'b01;
    press(1'b0, 4'h0, 1'b1, 1'b0);
    expect_trig(16'h1234);
    kt = cyc;
    expect_lock(kt + int'(P_RESP) + 1 + int'(P_RELOCK));
    idle(P_RESP + 1);
    check("open2_fail", 32'(fail_cnt), 0);
    idle(P_RELOCK + 2);
    lock_state = 2'b00;

    // Same-cycle clear and enter with four digits: clear wins.
    digit(4'h9);
    digit(4'h8);
    digit(4'h7);
    digit(4'h6);
    press(1'b1, 4'h3, 1'b1, 1'b1);
    check("clr_win_digit", 32'(digit_cnt), 0);
    check("clr_win_pin", 32'(pin_code), 0);
    check("clr_win_busy", 32'(busy), 0);
    idle(2);

    // Partial entry hold / timeout, with one failure already counted.
    digit(4'h7);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    check("pre_to_fail", 32'(fail_cnt), 1);
    digit(4'hC);
    digit(4'hA);
`ifdef PIN_ENTRY_TIMEOUT_EN
    idle(P_ENTRY_TO - 1);
    check("to_before", 32'(digit_cnt), 2);
    idle(1);
    check("to_digit", 32'(digit_cnt), 0);
    check("to_pin", 32'(pin_code), 0);
`else
    idle(P_ENTRY_TO + 20);
    check("hold_digit", 32'(digit_cnt), 2);
    check("hold_pin", 32'(pin_code), 32'h00CA);
`endif
    check("to_fail_kept", 32'(fail_cnt), 1);

    // Asynchronous reset cuts an in-flight trig.
    press(1'b1, 4'h0, 1'b0, 1'b1);
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    digit(4'h4);
    press(1'b0, 4'h0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_cut_trig", 32'(trig), 0);
    check("rst_cut_busy", 32'(busy), 0);
    check("rst_cut_fail", 32'(fail_cnt), 0);
    check("rst_cut_pin", 32'(pin_code), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    check("pending_events", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
